// File: rtl/reduce_engine.sv
// Multi-cycle bitwise reduction engine: folds LANES words per cycle into an accumulator
// and returns a column-wise result plus a single-bit full reduction.
module reduce_engine #(
  parameter int unsigned PORT_NUM = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LANES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [PORT_NUM*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_vec,
  output logic                      out_bit,
  output logic                      busy
);

  localparam int unsigned STEPS = PORT_NUM / LANES;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] ModeAnd  = 2'b00;
  localparam logic [1:0] ModeOr   = 2'b01;
  localparam logic [1:0] ModeXor  = 2'b10;
  localparam logic [1:0] ModeNand = 2'b11;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]          acc_q, acc_d;
  logic [PORT_NUM*WIDTH-1:0] data_q;
  logic [1:0]                mode_q;
  logic [WIDTH-1:0]          vec_q, vec_d;
  logic                      bit_q, bit_d;
  logic [WIDTH-1:0]          fold;
  logic                      accept;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StBusy);
  assign out_vec   = vec_q;
  assign out_bit   = bit_q;

  // Fold the current group of LANES words into the accumulator; NAND folds as AND.
  always_comb begin
    fold = acc_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      case (mode_q)
        ModeOr:  fold = fold | data_q[(int'(cnt_q) * LANES + l) * WIDTH +: WIDTH];
        ModeXor: fold = fold ^ data_q[(int'(cnt_q) * LANES + l) * WIDTH +: WIDTH];
        default: fold = fold & data_q[(int'(cnt_q) * LANES + l) * WIDTH +: WIDTH];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    vec_d   = vec_q;
    bit_d   = bit_q;

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StBusy;
      end
      StBusy: begin
        acc_d = fold;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
          vec_d   = (mode_q == ModeNand) ? ~fold : fold;
          case (mode_q)
            ModeAnd: bit_d = &fold;
            ModeOr:  bit_d = |fold;
            ModeXor: bit_d = ^fold;
            default: bit_d = ~&fold;
          endcase
        end
      end
      StDone: begin
        if (accept)         state_d = StBusy;
        else if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      cnt_d = '0;
      acc_d = (in_mode == ModeAnd || in_mode == ModeNand) ? '1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      mode_q  <= ModeAnd;
      vec_q   <= '0;
      bit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      bit_q   <= bit_d;
      if (accept) begin
        data_q <= in_data;
        mode_q <= in_mode;
      end
    end
  end

endmodule

// File: tb/tb_reduce_engine.sv
// Directed self-checking bench for reduce_engine (PORT_NUM=8, WIDTH=7, LANES=2).
module tb_reduce_engine;

  localparam int P = 8;
  localparam int W = 7;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_mode;
  logic [P*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_vec;
  logic           out_bit;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  reduce_engine #(.PORT_NUM(P), .WIDTH(W), .LANES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_bit   (out_bit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] mode, input logic [P*W-1:0] data);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_vec !== 7'h00 || out_bit !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b busy=%b vec=%h bit=%b, want 0 0 00 0",
               out_valid, busy, out_vec, out_bit);
    end
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_and_basic();
    int lat;
    send(2'b00, {P{7'h7F}});
    lat = 0;
    while (!out_valid && lat < 20) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL and_busy_phase: got in_ready=%b busy=%b want 0 1", in_ready, busy);
      end
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL and_latency: got %0d want 4", lat);
    end
    checks++;
    if (out_vec !== 7'h7F || out_bit !== 1'b1) begin
      failures++;
      $display("FAIL and_all_ones: got vec=%h bit=%b want 7f 1", out_vec, out_bit);
    end
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL and_drain: got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_and_nand();
    logic [P*W-1:0] d;
    int lat;
    d = {P{7'h7F}};
    d[5*W +: W] = 7'h7E;
    send(2'b00, d);
    wait_done(lat);
    checks++;
    if (lat !== 4 || out_vec !== 7'h7E || out_bit !== 1'b0) begin
      failures++;
      $display("FAIL and_one_zero: got lat=%0d vec=%h bit=%b want 4 7e 0", lat, out_vec, out_bit);
    end
    drain();
    send(2'b11, d);
    wait_done(lat);
    checks++;
    if (lat !== 4 || out_vec !== 7'h01 || out_bit !== 1'b1) begin
      failures++;
      $display("FAIL nand_one_zero: got lat=%0d vec=%h bit=%b want 4 01 1", lat, out_vec, out_bit);
    end
    drain();
    send(2'b11, {P{7'h7F}});
    wait_done(lat);
    checks++;
    if (lat !== 4 || out_vec !== 7'h00 || out_bit !== 1'b0) begin
      failures++;
      $display("FAIL nand_all_ones: got lat=%0d vec=%h bit=%b want 4 00 0", lat, out_vec, out_bit);
    end
    drain();
  endtask

  task automatic test_or_xor();
    logic [P*W-1:0] d;
    int lat;
    d = '0;
    d[0*W +: W] = 7'h01;
    d[7*W +: W] = 7'h40;
    send(2'b01, d);
    wait_done(lat);
    checks++;
    if (lat !== 4 || out_vec !== 7'h41 || out_bit !== 1'b1) begin
      failures++;
      $display("FAIL or_ends: got lat=%0d vec=%h bit=%b want 4 41 1", lat, out_vec, out_bit);
    end
    drain();
    d = {7'h01, 7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
    send(2'b10, d);
    wait_done(lat);
    checks++;
    if (lat !== 4 || out_vec !== 7'h7E || out_bit !== 1'b0) begin
      failures++;
      $display("FAIL xor_walk: got lat=%0d vec=%h bit=%b want 4 7e 0", lat, out_vec, out_bit);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    send(2'b00, {P{7'h7F}});
    wait_done(lat);
    checks++;
    if (lat !== 4 || out_vec !== 7'h7F || out_bit !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: got lat=%0d vec=%h bit=%b want 4 7f 1", lat, out_vec, out_bit);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_vec !== 7'h7F || out_bit !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d got valid=%b vec=%h bit=%b in_ready=%b want 1 7f 1 0",
                 i, out_valid, out_vec, out_bit, in_ready);
      end
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b01;
    in_data   = '0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_on_drain: got %b want 1", in_ready);
    end
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_drain_accept: got valid=%b busy=%b want 0 1", out_valid, busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 4 || out_vec !== 7'h00 || out_bit !== 1'b0) begin
      failures++;
      $display("FAIL bp_second: got lat=%0d vec=%h bit=%b want 4 00 0", lat, out_vec, out_bit);
    end
    drain();
  endtask

  task automatic test_capture();
    int lat;
    send(2'b10, {7'h01, 7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01});
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_data = {$urandom, $urandom};
      in_mode = 2'($urandom_range(0, 3));
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || out_vec !== 7'h7E || out_bit !== 1'b0) begin
      failures++;
      $display("FAIL capture: got lat=%0d vec=%h bit=%b want 4 7e 0", lat, out_vec, out_bit);
    end
    drain();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    int seen;
    send(2'b00, {P{7'h7F}});
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_vec !== 7'h00) begin
      failures++;
      $display("FAIL abort_state: got busy=%b in_ready=%b valid=%b vec=%h want 0 1 0 00",
               busy, in_ready, out_valid, out_vec);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
    end
    send(2'b00, {P{7'h7F}});
    wait_done(lat);
    checks++;
    if (lat !== 4 || out_vec !== 7'h7F || out_bit !== 1'b1) begin
      failures++;
      $display("FAIL after_abort: got lat=%0d vec=%h bit=%b want 4 7f 1", lat, out_vec, out_bit);
    end
    drain();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_and_basic();
    test_and_nand();
    test_or_xor();
    test_back_to_back();
    test_capture();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
